// File: rtl/serial_adder_ctrl_pkg.sv
// Shared ALU definitions: controller state encodings, operation codes and
// the counter-width helper used by the serial arithmetic blocks.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the serial adder: the master issues operations,
// the slave (the adder) returns status and the registered result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             Overflow;
  logic             Zero;

  modport master (
    output start, op, A, B,
    input  ready, busy, done, Result, Carry, Overflow, Zero
  );

  modport slave (
    input  start, op, A, B,
    output ready, busy, done, Result, Carry, Overflow, Zero
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder built from two half adders; this cell is the only
// arithmetic in the serial adder.
module Half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  Half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  Half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (cin),
    .sum   (sum),
    .carry (ha1_carry)
  );

  assign cout = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one operand bit per cycle, LSB first,
// through a single shared full adder; results are published only on DONE.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] a_sr_q,     a_sr_d;
  logic [WIDTH-1:0] b_sr_q,     b_sr_d;
  logic [WIDTH-2:0] res_sr_q,   res_sr_d;
  logic             carry_q,    carry_d;
  logic             ready_q,    ready_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             carry_o_q,  carry_o_d;
  logic             overflow_q, overflow_d;
  logic             zero_q,     zero_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] full_result;

  Full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Completed word as it stands on the final bit cycle.
  assign full_result = {fa_sum, res_sr_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_sr_d   = res_sr_q;
    carry_d    = carry_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    carry_o_d  = carry_o_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          state_d  = RUN;
          cnt_d    = '0;
          a_sr_d   = bus.A;
          b_sr_d   = (bus.op == OP_SUB) ? ~bus.B : bus.B;
          carry_d  = bus.op;
          res_sr_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end

      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = full_result[WIDTH-1:1];
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB on this last bit cycle.
          state_d    = DONE;
          done_d     = 1'b1;
          result_d   = full_result;
          carry_o_d  = fa_cout;
          overflow_d = carry_q ^ fa_cout;
          zero_d     = (full_result == '0);
        end
      end

      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_sr_q   <= '0;
      carry_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carry_o_q  <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_sr_q   <= res_sr_d;
      carry_q    <= carry_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      carry_o_q  <= carry_o_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Result   = result_q;
  assign bus.Carry    = carry_o_q;
  assign bus.Overflow = overflow_q;
  assign bus.Zero     = zero_q;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: Serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 start  input  1  SHALL be the operation request; it is sampled only when ready=1.
REQ-005 op  input  1  SHALL select the operation: 0 = add (A+B), 1 = subtract (A-B).
REQ-006 A  input  WIDTH  SHALL be operand A, captured on start acceptance.
REQ-007 B  input  WIDTH  SHALL be operand B, captured on start acceptance.
REQ-008 ready  output  1  SHALL be high only in state IDLE.
REQ-009 busy  output  1  SHALL be high in states RUN and DONE.
REQ-010 done  output  1  SHALL be a single-cycle pulse marking result valid.
REQ-011 Result  output  WIDTH  SHALL be the sum or difference.
REQ-012 Carry  output  1  SHALL be the final carry-out; for subtract, 1 means no borrow.
REQ-013 Overflow  output  1  SHALL flag signed overflow, equal to MSB carry-in XOR MSB carry-out.
REQ-014 Zero  output  1  SHALL be high when Result equals 0.

Function
REQ-015 The block SHALL compute bit-serially, LSB first, through one shared full-adder cell, processing one bit per cycle.
REQ-016 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on start=1; RUN->DONE after WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 On acceptance, the block SHALL load A into the A shift register, load B (add) or ~B (subtract) into the B shift register, set the carry register to op, and clear the bit counter.
REQ-018 Each RUN cycle SHALL feed the LSBs of both shift registers and the carry register to the full adder, shift the sum bit into the Result register MSB, shift the operands right, store carry-out, and increment the counter.
REQ-019 The block SHALL capture the carry into the MSB on the final RUN cycle for the Overflow computation.
REQ-020 done SHALL assert exactly WIDTH cycles after the edge that accepted start, and SHALL stay high for exactly one cycle.
REQ-021 Result, Carry, Overflow and Zero SHALL be valid from the done cycle and SHALL hold until the next accepted start.
REQ-022 Output registers SHALL update only on the transition into DONE; they SHALL NOT show intermediate values during RUN.
REQ-023 start and operand changes SHALL be ignored while busy=1; operands are not required to stay stable after acceptance.
REQ-024 If start is held high continuously, a new operation SHALL be accepted on the first IDLE cycle after DONE, giving a repetition period of WIDTH+2 cycles.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with the carry reported only through Carry.

Reset
REQ-026 When rst=1 at a clock edge, the state SHALL become IDLE, the counter and all shift and carry registers SHALL clear, and outputs SHALL read ready=1, busy=0, done=0, Result=0, Carry=0, Overflow=0, Zero=0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; rst SHALL take priority over start in the same cycle.

Structure
REQ-028 A shared header SHALL hold the state encodings (IDLE, RUN, DONE) and the op codes (OP_ADD=0, OP_SUB=1), reused by the other ALU blocks.
REQ-029 The full-adder cell SHALL be a separate sub-module, Full_adder, built from two Half_adder instances and an OR of their carries; it is the only arithmetic logic in the block.
REQ-030 The counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-031 Add: op=0, A=8'h0F, B=8'h01 -> Result=8'h10, Carry=0, Overflow=0, Zero=0; done exactly 8 cycles after acceptance.
REQ-032 Add wrap: A=8'hFF, B=8'h01, op=0 -> Result=8'h00, Carry=1, Zero=1, Overflow=0.
REQ-033 Signed overflow: A=8'h7F, B=8'h01, op=0 -> Result=8'h80, Overflow=1, Carry=0; subtract A=8'h80, B=8'h01 -> Result=8'h7F, Overflow=1, Carry=1.
REQ-034 Borrow: op=1, A=8'h05, B=8'h07 -> Result=8'hFE, Carry=0, Overflow=0, Zero=0.
REQ-035 Start pulse plus changed operands during RUN -> ignored, result matches the first operation; start held high -> second acceptance 10 cycles after the first.
REQ-036 rst at the 4th RUN cycle -> the next cycle shows ready=1, busy=0, all outputs 0, and no done pulse; a following add 8'h03+8'h04 -> Result=8'h07.
